// File: rtl/gba_sound_pkg.sv
// Shared sound-channel definitions: duty waveform rows, frequency width and
// length-counter full scale used by the square and noise channels.
package gba_sound_pkg;

    localparam int FREQ_W  = 11;
    localparam int LEN_MAX = 64;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_t;

    // Bit n of a row is the waveform level at duty step n.
    localparam logic [7:0] DUTY_TABLE [4] = '{
        8'b0000_0001,
        8'b1000_0001,
        8'b1000_0111,
        8'b0111_1110
    };

    function automatic logic duty_level(input duty_t duty, input logic [2:0] step);
        logic [7:0] row;
        row = DUTY_TABLE[duty];
        return row[step];
    endfunction

endpackage

// File: rtl/square_duty_generator_length_counter.sv
// Length counter shared by channels 1, 2 and 4: loads from a 6-bit field,
// counts down on the 256 Hz tick and pulses o_expire on the 1->0 step.
module length_counter
    import gba_sound_pkg::*;
#(
    parameter int LEN_FULL = LEN_MAX
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [5:0] i_load_val,
    input  logic       i_tick,
    input  logic       i_enable,
    input  logic       i_trigger,
    output logic       o_expire
);

    localparam logic [6:0] FULL = 7'(LEN_FULL);

    logic [6:0] r_count;
    logic [6:0] w_loaded;
    logic [6:0] w_next;
    logic       w_dec;

    // A register write lands before a same-cycle trigger looks at the count,
    // and a trigger always swallows a same-cycle length clock.
    always_comb begin
        w_loaded = i_load ? (FULL - {1'b0, i_load_val}) : r_count;
        w_dec    = i_tick && i_enable && !i_trigger && !i_load && (r_count != 7'd0);
        w_next   = w_loaded;
        if (i_trigger && (w_loaded == 7'd0)) begin
            w_next = FULL;
        end else if (w_dec) begin
            w_next = r_count - 7'd1;
        end
    end

    assign o_expire = w_dec && (r_count == 7'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 7'd0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/square_duty_generator.sv
// Channel 1 tone stage: period timer, 8-step duty sequencer, length gating and
// the registered 4-bit sample handed to the mixer.
module square_duty_generator
    import gba_sound_pkg::FREQ_W, gba_sound_pkg::duty_t, gba_sound_pkg::duty_level;
#(
    parameter int PRESCALE = 4,
    parameter int LEN_MAX  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              timer_tick,
    input  logic              tick_256,
    input  logic [FREQ_W-1:0] freq,
    input  logic              sweep_ok,
    input  logic [7:0]        nr11,
    input  logic              nr11_wr,
    input  logic              length_en,
    input  logic              trigger,
    input  logic [3:0]        volume,
    output logic              active,
    output logic [3:0]        sample
);

    localparam int TIMER_W = FREQ_W + $clog2(PRESCALE);

    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_duty_step;
    logic               r_active;
    logic [3:0]         r_sample;

    logic [TIMER_W:0]   w_reload_full;
    logic [TIMER_W-1:0] w_reload;
    logic               w_advance;
    logic               w_expire;
    logic               w_level;

    // freq=0 would need one bit more than the timer holds; it saturates instead.
    assign w_reload_full = (TIMER_W+1)'((12'd2048 - {1'b0, freq}) * PRESCALE);
    assign w_reload      = w_reload_full[TIMER_W] ? '1 : w_reload_full[TIMER_W-1:0];

    assign w_advance = timer_tick && !trigger && (r_timer <= TIMER_W'(1));
    assign w_level   = duty_level(duty_t'(nr11[7:6]), r_duty_step);

    length_counter #(
        .LEN_FULL (LEN_MAX)
    ) u_length (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (nr11_wr),
        .i_load_val (nr11[5:0]),
        .i_tick     (tick_256),
        .i_enable   (length_en),
        .i_trigger  (trigger),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer     <= '0;
            r_duty_step <= 3'd0;
        end else begin
            if (trigger || w_advance) begin
                r_timer <= w_reload;
            end else if (timer_tick) begin
                r_timer <= r_timer - TIMER_W'(1);
            end
            if (w_advance) begin
                r_duty_step <= r_duty_step + 3'd1;
            end
        end
    end

    // The timer keeps running while the channel is off; only the sample is gated.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_sample <= 4'h0;
        end else begin
            if (trigger && sweep_ok) begin
                r_active <= 1'b1;
            end else if (!sweep_ok || w_expire) begin
                r_active <= 1'b0;
            end
            r_sample <= (r_active && w_level) ? volume : 4'h0;
        end
    end

    assign active = r_active;
    assign sample = r_sample;

endmodule

// File: tb/tb_square_duty_generator.sv
// Scoreboard bench for square_duty_generator: expected {active, sample} pairs
// are queued as stimulus is applied and compared once the DUT has clocked.
module tb_square_duty_generator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        timer_tick;
    logic        tick_256;
    logic [10:0] freq;
    logic        sweep_ok;
    logic [7:0]  nr11;
    logic        nr11_wr;
    logic        length_en;
    logic        trigger;
    logic [3:0]  volume;
    logic        active;
    logic [3:0]  sample;

    typedef struct packed {
        logic       act;
        logic [3:0] smp;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [7:0] ROW [4] = '{8'h01, 8'h81, 8'h87, 8'h7E};

    always #5 clock = ~clock;

    square_duty_generator #(
        .PRESCALE (4),
        .LEN_MAX  (64)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .timer_tick (timer_tick),
        .tick_256   (tick_256),
        .freq       (freq),
        .sweep_ok   (sweep_ok),
        .nr11       (nr11),
        .nr11_wr    (nr11_wr),
        .length_en  (length_en),
        .trigger    (trigger),
        .volume     (volume),
        .active     (active),
        .sample     (sample)
    );

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        timer_tick = 1'b0;
        tick_256   = 1'b0;
        freq       = 11'd0;
        sweep_ok   = 1'b1;
        nr11       = 8'h00;
        nr11_wr    = 1'b0;
        length_en  = 1'b0;
        trigger    = 1'b0;
        volume     = 4'h0;
        reset_n    = 1'b0;
        step(2);
        reset_n    = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        apply_reset();
        exp_q.push_back('{1'b0, 4'h0});
        e = exp_q.pop_front(); n_chk++;
        if ({active, sample} !== e) $display("FAIL reset_state: active/sample=%b/%h expected %b/%h", active, sample, e.act, e.smp);
        else n_pass++;

        freq = 11'd2047; nr11 = 8'hC0; volume = 4'hF;
        trigger = 1'b1; timer_tick = 1'b1;
        step(1);
        trigger = 1'b0;
        exp_q.push_back('{1'b1, 4'hF});
        step(5);
        timer_tick = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if ({active, sample} !== e) $display("FAIL reset_prenote: active/sample=%b/%h expected %b/%h", active, sample, e.act, e.smp);
        else n_pass++;

        exp_q.push_back('{1'b0, 4'h0});
        reset_n = 1'b0;
        #1;
        e = exp_q.pop_front(); n_chk++;
        if ({active, sample} !== e) $display("FAIL reset_async: active/sample=%b/%h expected %b/%h", active, sample, e.act, e.smp);
        else n_pass++;
        step(2);
        reset_n = 1'b1;
        exp_q.push_back('{1'b0, 4'h0});
        step(1);
        e = exp_q.pop_front(); n_chk++;
        if ({active, sample} !== e) $display("FAIL reset_release: active/sample=%b/%h expected %b/%h", active, sample, e.act, e.smp);
        else n_pass++;

        // Duty step must be back at 0: row 11 reads low there, row 00 high.
        for (int i = 0; i < 3; i++) begin
            trigger = (i == 0);
            nr11    = (i == 2) ? 8'h00 : 8'hC0;
            exp_q.push_back('{1'b1, (i == 2) ? 4'hF : 4'h0});
            step(1);
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL reset_step0[%0d]: active/sample=%b/%h expected %b/%h", i, active, sample, e.act, e.smp);
            else n_pass++;
        end
        trigger = 1'b0;
    endtask

    task automatic test_period();
        logic [7:0] row;
        apply_reset();
        freq = 11'd2040; nr11 = 8'h80; volume = 4'hF;
        row = ROW[2];
        trigger = 1'b1; timer_tick = 1'b1;
        for (int p = 0; p <= 264; p++) begin
            if (p == 0) exp_q.push_back('{1'b1, 4'h0});
            else        exp_q.push_back('{1'b1, row[((p - 1) / 32) % 8] ? 4'hF : 4'h0});
            step(1);
            trigger = 1'b0;
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL period[%0d]: active/sample=%b/%h expected %b/%h", p, active, sample, e.act, e.smp);
            else n_pass++;
        end
        timer_tick = 1'b0;
    endtask

    task automatic test_length();
        logic       tk [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       ac [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] sm [7] = '{4'h0, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0};
        apply_reset();
        volume = 4'hA; nr11 = 8'h3E; nr11_wr = 1'b1;
        step(1);
        nr11_wr = 1'b0; length_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            trigger  = (i == 0);
            tick_256 = tk[i];
            exp_q.push_back('{ac[i], sm[i]});
            step(1);
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL length[%0d]: active/sample=%b/%h expected %b/%h", i, active, sample, e.act, e.smp);
            else n_pass++;
        end
        trigger = 1'b0; tick_256 = 1'b0;
    endtask

    task automatic test_length_reload();
        apply_reset();
        volume = 4'h5; nr11 = 8'h00; length_en = 1'b1;
        // Phase 0: plain trigger from an empty counter; phase 1: trigger with a length clock.
        for (int ph = 0; ph < 2; ph++) begin
            trigger = 1'b1; tick_256 = (ph == 1);
            exp_q.push_back('{1'b1, 4'h0});
            step(1);
            trigger = 1'b0; tick_256 = 1'b0;
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL reload_trig[%0d]: active/sample=%b/%h expected %b/%h", ph, active, sample, e.act, e.smp);
            else n_pass++;
            step(1);
            for (int k = 1; k <= 64; k++) begin
                tick_256 = 1'b1;
                exp_q.push_back('{(k < 64), 4'h5});
                step(1);
                tick_256 = 1'b0;
                e = exp_q.pop_front(); n_chk++;
                if ({active, sample} !== e) $display("FAIL reload_tick[%0d.%0d]: active/sample=%b/%h expected %b/%h", ph, k, active, sample, e.act, e.smp);
                else n_pass++;
                step(1);
            end
        end
        // Register write and trigger together: the trigger sees a count of 1.
        nr11 = 8'h3F; nr11_wr = 1'b1; trigger = 1'b1;
        exp_q.push_back('{1'b1, 4'h0});
        step(1);
        nr11_wr = 1'b0; trigger = 1'b0; tick_256 = 1'b1;
        exp_q.push_back('{1'b0, 4'h5});
        step(1);
        tick_256 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); n_chk++;
            if (i == 0 ? ({1'b1, 4'h0} !== e) : ({active, sample} !== e))
                $display("FAIL wr_trig[%0d]: queue/active/sample=%b/%h expected %b/%h", i, active, sample, e.act, e.smp);
            else n_pass++;
        end
    endtask

    task automatic test_sweep_kill();
        logic       tg [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       ok [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       ac [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] sm [9] = '{4'h0, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7};
        apply_reset();
        volume = 4'h7; nr11 = 8'h00;
        for (int i = 0; i < 9; i++) begin
            trigger  = tg[i];
            sweep_ok = ok[i];
            exp_q.push_back('{ac[i], sm[i]});
            step(1);
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL sweep_kill[%0d]: active/sample=%b/%h expected %b/%h", i, active, sample, e.act, e.smp);
            else n_pass++;
        end
        trigger = 1'b0; sweep_ok = 1'b1;
    endtask

    task automatic test_wrap_edge();
        logic [7:0] row;
        apply_reset();
        freq = 11'd2047; nr11 = 8'h00; volume = 4'hF;
        trigger = 1'b1; timer_tick = 1'b1;
        for (int p = 0; p <= 48; p++) begin
            if (p == 42) nr11 = 8'hC0;
            row = (p >= 42) ? ROW[3] : ROW[0];
            if (p == 0) exp_q.push_back('{1'b1, 4'h0});
            else        exp_q.push_back('{1'b1, row[((p - 1) / 4) % 8] ? 4'hF : 4'h0});
            step(1);
            trigger = 1'b0;
            e = exp_q.pop_front(); n_chk++;
            if ({active, sample} !== e) $display("FAIL wrap[%0d]: active/sample=%b/%h expected %b/%h", p, active, sample, e.act, e.smp);
            else n_pass++;
        end
        timer_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_period();
        test_length();
        test_length_reload();
        test_sweep_kill();
        test_wrap_edge();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
